// File: rtl/enc83_seq_if.sv
// Handshake bundle for enc83_seq: the vector input side and the index output side.
// master = producer/consumer (bench or upstream), slave = encoder.
interface enc83_seq_if #(
    parameter int N  = 8,
    parameter int AW = 3,
    parameter int CW = 4
);
    logic [N-1:0]  in;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] count;
    logic          zero_drop;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, out_last, count, zero_drop
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, out_last, count, zero_drop
    );
endinterface

// File: rtl/enc83_seq.sv
// Sequential 8->3 encoder: emits the index of every set bit of an accepted vector, one per handshake.
// Define ENC_MSB_FIRST_EN to emit highest index first (default: lowest first).
module enc83_seq #(
    parameter int N  = 8,
    parameter int AW = 3,
    parameter int CW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    enc83_seq_if.slave  bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic          zero_drop_q, zero_drop_d;

    logic [AW-1:0] sel_idx;
    logic [N-1:0]  sel_mask;
    logic [CW-1:0] pop;
    logic          emit, out_fire, accept;

    always_comb begin
        sel_idx  = '0;
        pop      = '0;
        // Loop direction picks the priority: the last matching write wins.
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++)
            if (pending_q[i]) sel_idx = AW'(i);
`else
        for (int i = N - 1; i >= 0; i--)
            if (pending_q[i]) sel_idx = AW'(i);
`endif
        for (int i = 0; i < N; i++)
            pop = pop + CW'(pending_q[i]);
        sel_mask = N'(1) << sel_idx;
    end

    assign emit          = (state_q == ST_EMIT);
    assign bus.out_valid = emit;
    assign bus.out       = emit ? sel_idx : '0;
    assign bus.count     = emit ? pop : '0;
    assign bus.out_last  = emit && (pop == CW'(1));
    assign bus.zero_drop = zero_drop_q;

    assign out_fire      = emit & bus.out_ready;
    // Accepting on the last handshake lets vectors stream with no idle bubble.
    assign bus.in_ready  = ~emit | (out_fire & bus.out_last);
    assign accept        = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        if (out_fire) begin
            pending_d = pending_q & ~sel_mask;
            if (bus.out_last) state_d = ST_IDLE;
        end
        if (accept) begin
            if (bus.in != '0) begin
                pending_d = bus.in;
                state_d   = ST_EMIT;
            end else begin
                pending_d   = '0;
                state_d     = ST_IDLE;
                zero_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end
endmodule

// File: tb/tb_enc83_seq.sv
// Bench for enc83_seq: queue-of-indices reference model checked every cycle, directed cases plus random traffic.
module tb_enc83_seq;
    logic clk;
    logic rst_n;
    enc83_seq_if #(.N(8), .AW(3), .CW(4)) bus ();

    enc83_seq #(.N(8), .AW(3), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;
    int or_mode = 0;
    int cyc = 0;

    int mq[$];       // model: indices still to be emitted, in emission order
    bit m_zd = 0;    // model: zero_drop expected this cycle
    int emitted[$];  // indices actually handed over by the DUT

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model rule: a vector turns into the list of its set-bit positions in emission order.
    task automatic load_model(input logic [7:0] v);
        mq.delete();
`ifdef ENC_MSB_FIRST_EN
        for (int i = 7; i >= 0; i--) if (v[i]) mq.push_back(i);
`else
        for (int i = 0; i < 8; i++) if (v[i]) mq.push_back(i);
`endif
    endtask

    // Compare at negedge; inputs are changed only just after posedge.
    always @(negedge clk) begin
        int sz;
        bit fire, rdy;
        if (chk_en) begin
            sz = mq.size();
            fire = (sz > 0) && bus.out_ready;
            rdy = (sz == 0) || (fire && sz == 1);
            chk("out_valid", bus.out_valid, sz > 0);
            chk("out", bus.out, (sz > 0) ? mq[0] : 0);
            chk("count", bus.count, sz);
            chk("out_last", bus.out_last, sz == 1);
            chk("in_ready", bus.in_ready, rdy);
            chk("zero_drop", bus.zero_drop, m_zd);
            if (!rst_n) begin
                mq.delete();
                m_zd = 0;
            end else begin
                if (fire) begin
                    emitted.push_back(int'(bus.out));
                    void'(mq.pop_front());
                end
                m_zd = 0;
                if (bus.in_valid && rdy) begin
                    if (bus.in == 8'h00) m_zd = 1;
                    else load_model(bus.in);
                end
            end
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #2;
        cyc++;
        if (or_mode == 1) bus.out_ready = (cyc % 3 == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_step();
    endtask

    task automatic send(input logic [7:0] v);
        logic acc;
        acc = 1'b0;
        bus.in = v;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            cyc_step();
        end
        bus.in_valid = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic chk_list(input string nm, input int exp[$]);
        chk($sformatf("%s_len", nm), emitted.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (i < emitted.size()) chk($sformatf("%s_idx%0d", nm, i), emitted[i], exp[i]);
    endtask

    initial begin
        int e[$];
        rst_n = 1'b0;
        bus.in = 8'h00;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1;
        cyc_step();
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        cyc_step();

        // single bit, 1-cycle latency
        send(8'h04);
        @(negedge clk);
        chk("t1_out", bus.out, 2);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_last", bus.out_last, 1);
        chk("t1_count", bus.count, 1);
        cyc_step();
        @(negedge clk);
        chk("t1_idle_valid", bus.out_valid, 0);
        chk("t1_idle_ready", bus.in_ready, 1);
        cyc_step();

        // multi-hot ordering
        emitted.delete();
        send(8'b1010_0110);
        idle(6);
`ifdef ENC_MSB_FIRST_EN
        e = '{7, 5, 2, 1};
`else
        e = '{1, 2, 5, 7};
`endif
        chk_list("t2", e);

        // backpressure: out_ready toggles
        emitted.delete();
        or_mode = 1;
        send(8'hFF);
        idle(30);
        or_mode = 0;
        bus.out_ready = 1'b1;
`ifdef ENC_MSB_FIRST_EN
        e = '{7, 6, 5, 4, 3, 2, 1, 0};
`else
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        chk_list("t3", e);

        // back-to-back: second vector taken on the last handshake
        emitted.delete();
        send(8'b0001_0001);
        send(8'b1000_0000);
        @(negedge clk);
        chk("b2b_out", bus.out, 7);
        chk("b2b_valid", bus.out_valid, 1);
        idle(4);
`ifdef ENC_MSB_FIRST_EN
        e = '{4, 0, 7};
`else
        e = '{0, 4, 7};
`endif
        chk_list("t4", e);

        // zero vector
        send(8'h00);
        @(negedge clk);
        chk("zd_pulse", bus.zero_drop, 1);
        chk("zd_valid", bus.out_valid, 0);
        chk("zd_ready", bus.in_ready, 1);
        cyc_step();
        @(negedge clk);
        chk("zd_clear", bus.zero_drop, 0);
        cyc_step();

        // reset mid-emission
        emitted.delete();
        send(8'hF0);
        cyc_step();
        rst_n = 1'b0;
        cyc_step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_count", bus.count, 0);
        chk("mr_ready", bus.in_ready, 1);
        idle(6);
        chk("mr_emitted", emitted.size(), 1);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            bus.in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.in_valid = $urandom_range(0, 2) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            rst_n = ($urandom_range(0, 59) != 0);
            cyc_step();
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        idle(12);
        chk("final_idle", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
